l2_pri_bank_arbiter: RTL and testbench
======================================

Name: l2_pri_bank_arbiter

Overview:
Two-requester round-robin arbiter and clear sequencer for one private L2 SRAM bank, e.g. the 8192x32 private bank.
- Muxes TCDM-style req/gnt/r_valid masters (port 0: FC data, port 1: uDMA) onto the single csn/wen/be bank interface.
- Owns a hardware clear FSM that zero-fills the whole bank on request, during which both masters are stalled.
- Sits between the SoC interconnect and the bank macro.

Parameters:
ADDR_WIDTH, 13, word-address width on master and bank side
DEPTH, 8192, number of implemented 32-bit words; legal range 1..2^ADDR_WIDTH
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m_req_i  in  2  per-master request, bit k = master k
m_gnt_o  out  2  per-master grant, combinational in the request cycle
m_wen_i  in  2  per-master write enable, active-low (0 = write)
m_add_i  in  2*ADDR_WIDTH  per-master word address, master k in slice k
m_be_i  in  2*DATA_WIDTH/8  per-master byte enables, active-high
m_wdata_i  in  2*DATA_WIDTH  per-master write data
m_r_valid_o  out  2  response valid, one cycle after grant
m_r_rdata_o  out  DATA_WIDTH  shared read data, qualified by m_r_valid_o
mem_csn_o  out  1  bank chip select, active-low
mem_wen_o  out  1  bank write enable, active-low
mem_be_o  out  DATA_WIDTH/8  bank byte enables, active-high (macro inversion done outside)
mem_add_o  out  ADDR_WIDTH  bank word address
mem_wdata_o  out  DATA_WIDTH  bank write data
mem_rdata_i  in  DATA_WIDTH  bank read data, valid one cycle after csn low with wen high
clear_req_i  in  1  start zero-fill, level sampled in IDLE
clear_busy_o  out  1  high while the FSM is in CLEAR
clear_done_o  out  1  single-cycle pulse on the last clear write

Behaviour:
- Reset values: m_gnt_o=0, m_r_valid_o=0, m_r_rdata_o=0, mem_csn_o=1, mem_wen_o=1, mem_be_o=0, mem_add_o=0, mem_wdata_o=0, clear_busy_o=0, clear_done_o=0. Priority pointer=0, FSM=IDLE.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req_i=1. The transition is registered; the cycle in which clear_req_i is first seen still arbitrates masters normally.
  - CLEAR -> IDLE after the write to address DEPTH-1.
- Arbitration (IDLE only):
  - Exactly one requester: that master is granted.
  - Both requesting: the master equal to the pointer is granted.
  - After any grant, the pointer is set to the other master (the pointer holds when there is no grant).
  - At most one m_gnt_o bit is high per cycle.
  - Bank outputs are driven combinationally from the granted master. mem_csn_o=0 only for an in-range grant.
- Response path:
  - Registered winner id and read flag; m_r_valid_o[id]=1 exactly one cycle after every grant, for reads and writes.
  - Read: m_r_rdata_o=mem_rdata_i in the response cycle.
  - Write: m_r_rdata_o holds its previous value.
  - Back-to-back grants give back-to-back r_valid; throughput is 1 access/cycle.
- Out-of-range (m_add_i >= DEPTH):
  - Granted with mem_csn_o=1 and r_valid one cycle later.
  - A read returns 32'hBADACCE5. A write is dropped.
- CLEAR:
  - m_gnt_o=0 and clear_busy_o=1.
  - One write per cycle: mem_csn_o=0, mem_wen_o=0, mem_be_o all-ones, mem_wdata_o=0.
  - Internal counter drives mem_add_o 0..DEPTH-1, then wraps to 0 on exit.
  - clear_done_o=1 in the cycle the DEPTH-1 write is issued.
  - clear_req_i is ignored while in CLEAR; a still-high level on return to IDLE starts a new clear next cycle.
  - Pending requests stay stalled (no grant, no r_valid) and resume on the first IDLE cycle.
- Response on entering CLEAR: a response owed from a grant issued in the final IDLE cycle is still delivered in the first CLEAR cycle.
- Reset mid-operation: asynchronous return to the reset values. Any clear in progress is abandoned (bank partially cleared) and any outstanding response is dropped.

Test Plan:
- Master 0 writes 32'hDEADBEEF to addr 0x10 with be=4'hF, then reads 0x10 -> r_valid[0] one cycle after each grant; read returns 32'hDEADBEEF.
- Both masters request reads every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; r_valid alternates the same one cycle later; never both high.
- Master 1 writes 32'h11223344 with be=4'b0101 over 32'hFFFFFFFF at addr 5, then reads -> 32'hFF22FF44.
- Pulse clear_req_i with DEPTH=16 while master 0 holds req -> clear_busy_o high for 16 cycles, addresses 0..15, clear_done_o on addr 15, gnt[0] on the next cycle; a read of addr 5 returns 0.
- Master 0 reads addr 8191 with DEPTH=8000 -> mem_csn_o stays 1; r_valid[0] with rdata 32'hBADACCE5.
- Assert rst_ni low at clear address 7 -> all outputs return to reset values immediately; after release, a normal grant occurs without a clear.

Source files
------------

// File: rtl/l2_pri_bank_arbiter.sv
// Two-master round-robin arbiter for one private L2 bank, with a hardware
// zero-fill sequencer that stalls both masters while it sweeps the bank.
module l2_pri_bank_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 8192,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [1:0]                  m_req_i,
  output logic [1:0]                  m_gnt_o,
  input  logic [1:0]                  m_wen_i,
  input  logic [2*ADDR_WIDTH-1:0]     m_add_i,
  input  logic [2*DATA_WIDTH/8-1:0]   m_be_i,
  input  logic [2*DATA_WIDTH-1:0]     m_wdata_i,
  output logic [1:0]                  m_r_valid_o,
  output logic [DATA_WIDTH-1:0]       m_r_rdata_o,
  output logic                        mem_csn_o,
  output logic                        mem_wen_o,
  output logic [DATA_WIDTH/8-1:0]     mem_be_o,
  output logic [ADDR_WIDTH-1:0]       mem_add_o,
  output logic [DATA_WIDTH-1:0]       mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]       mem_rdata_i,
  input  logic                        clear_req_i,
  output logic                        clear_busy_o,
  output logic                        clear_done_o
);

  localparam int                    BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] OOR_DATA = DATA_WIDTH'(32'hBADACCE5);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_ptr;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;
  logic                    r_rsp_valid, r_rsp_id, r_rsp_read, r_rsp_oor;
  logic [DATA_WIDTH-1:0]   r_rdata_hold;

  logic [1:0]              w_gnt;
  logic                    w_sel, w_any, w_oor, w_last;
  logic [ADDR_WIDTH-1:0]   w_sel_add;
  logic                    w_sel_wen;
  logic [BE_WIDTH-1:0]     w_sel_be;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic [DATA_WIDTH-1:0]   w_rdata;

  assign w_last = (r_clr_addr == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear_req_i) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_last)      w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ties go to the pointer; a lone requester always wins.
  always_comb begin
    w_gnt = 2'b00;
    w_sel = 1'b0;
    if (r_state == S_IDLE) begin
      case (m_req_i)
        2'b01:   begin w_gnt = 2'b01; w_sel = 1'b0; end
        2'b10:   begin w_gnt = 2'b10; w_sel = 1'b1; end
        2'b11:   begin w_gnt = r_ptr ? 2'b10 : 2'b01; w_sel = r_ptr; end
        default: begin w_gnt = 2'b00; w_sel = 1'b0; end
      endcase
    end
  end

  assign w_any       = |w_gnt;
  assign w_sel_add   = w_sel ? m_add_i[ADDR_WIDTH +: ADDR_WIDTH]   : m_add_i[0 +: ADDR_WIDTH];
  assign w_sel_wen   = w_sel ? m_wen_i[1]                          : m_wen_i[0];
  assign w_sel_be    = w_sel ? m_be_i[BE_WIDTH +: BE_WIDTH]        : m_be_i[0 +: BE_WIDTH];
  assign w_sel_wdata = w_sel ? m_wdata_i[DATA_WIDTH +: DATA_WIDTH] : m_wdata_i[0 +: DATA_WIDTH];
  assign w_oor       = ({1'b0, w_sel_add} >= DEPTH_W);
  assign m_gnt_o     = w_gnt;

  always_comb begin
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_be_o    = '0;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    if (r_state == S_CLEAR) begin
      mem_csn_o = 1'b0;
      mem_wen_o = 1'b0;
      mem_be_o  = '1;
      mem_add_o = r_clr_addr;
    end else if (w_any) begin
      mem_csn_o   = w_oor;
      mem_wen_o   = w_sel_wen;
      mem_be_o    = w_sel_be;
      mem_add_o   = w_sel_add;
      mem_wdata_o = w_sel_wdata;
    end
  end

  assign clear_busy_o = (r_state == S_CLEAR);
  assign clear_done_o = (r_state == S_CLEAR) && w_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_clr_addr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_addr <= w_last ? '0 : r_clr_addr + 1'b1;
    end
  end

  // Response bookkeeping is independent of the FSM so a grant in the last
  // IDLE cycle still gets its response in the first CLEAR cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_read  <= 1'b0;
      r_rsp_oor   <= 1'b0;
    end else begin
      r_rsp_valid <= w_any;
      if (w_any) begin
        r_ptr      <= ~w_sel;
        r_rsp_id   <= w_sel;
        r_rsp_read <= w_sel_wen;
        r_rsp_oor  <= w_oor;
      end
    end
  end

  always_comb begin
    w_rdata = r_rdata_hold;
    if (r_rsp_valid && r_rsp_read) w_rdata = r_rsp_oor ? OOR_DATA : mem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         r_rdata_hold <= '0;
    else if (r_rsp_valid && r_rsp_read)  r_rdata_hold <= w_rdata;
  end

  assign m_r_rdata_o = w_rdata;
  assign m_r_valid_o = {r_rsp_valid & r_rsp_id, r_rsp_valid & ~r_rsp_id};

endmodule

// File: tb/tb_l2_pri_bank_arbiter.sv
// Directed bench: dutA (DEPTH=8000) covers arbitration and data paths,
// dutB (DEPTH=16) shares the master stimulus and covers the clear sequencer.
module tb_l2_pri_bank_arbiter;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        initMem = 1'b0;
  logic [1:0]  req = '0, wen = '1;
  logic [25:0] add = '0;
  logic [7:0]  be = '0;
  logic [63:0] wdata = '0;
  logic        clrReqA = 1'b0, clrReqB = 1'b0;

  logic [1:0]  gntA, rvA, gntB, rvB;
  logic [31:0] rdA, rdB, wdA, wdB, rdInA, rdInB;
  logic        csnA, wenA, busyA, doneA, csnB, wenB, busyB, doneB;
  logic [3:0]  beA, beB;
  logic [12:0] addA, addB;

  logic [31:0] memA [0:8191];
  logic [31:0] memB [0:8191];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_pri_bank_arbiter #(.ADDR_WIDTH(13), .DEPTH(8000), .DATA_WIDTH(32)) dutA (
    .clk_i(clk), .rst_ni(rstN), .m_req_i(req), .m_gnt_o(gntA), .m_wen_i(wen),
    .m_add_i(add), .m_be_i(be), .m_wdata_i(wdata), .m_r_valid_o(rvA), .m_r_rdata_o(rdA),
    .mem_csn_o(csnA), .mem_wen_o(wenA), .mem_be_o(beA), .mem_add_o(addA),
    .mem_wdata_o(wdA), .mem_rdata_i(rdInA), .clear_req_i(clrReqA),
    .clear_busy_o(busyA), .clear_done_o(doneA));

  l2_pri_bank_arbiter #(.ADDR_WIDTH(13), .DEPTH(16), .DATA_WIDTH(32)) dutB (
    .clk_i(clk), .rst_ni(rstN), .m_req_i(req), .m_gnt_o(gntB), .m_wen_i(wen),
    .m_add_i(add), .m_be_i(be), .m_wdata_i(wdata), .m_r_valid_o(rvB), .m_r_rdata_o(rdB),
    .mem_csn_o(csnB), .mem_wen_o(wenB), .mem_be_o(beB), .mem_add_o(addB),
    .mem_wdata_o(wdB), .mem_rdata_i(rdInB), .clear_req_i(clrReqB),
    .clear_busy_o(busyB), .clear_done_o(doneB));

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Bank models: registered read, byte-masked write, preloaded with a pattern.
  always @(posedge clk) begin
    if (initMem) begin
      for (int i = 0; i < 8192; i++) memA[i] <= pat(i);
    end else if (!csnA) begin
      if (!wenA) begin
        for (int b = 0; b < 4; b++) if (beA[b]) memA[addA][8*b +: 8] <= wdA[8*b +: 8];
      end else rdInA <= memA[addA];
    end
  end

  always @(posedge clk) begin
    if (initMem) begin
      for (int i = 0; i < 8192; i++) memB[i] <= pat(i);
    end else if (!csnB) begin
      if (!wenB) begin
        for (int b = 0; b < 4; b++) if (beB[b]) memB[addB][8*b +: 8] <= wdB[8*b +: 8];
      end else rdInB <= memB[addB];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [12:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[k] = r;
    wen[k] = w;
    add[k*13 +: 13] = a;
    be[k*4 +: 4] = b;
    wdata[k*32 +: 32] = d;
  endtask

  task automatic idle();
    req = 2'b00;
    wen = 2'b11;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    initMem = 1'b1;
    tick();
    initMem = 1'b0;
    checks++; if (gntA !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gntA); end
    checks++; if (rvA !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", rvA); end
    checks++; if (rdA !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdA); end
    checks++; if ({csnA, wenA, beA, addA, wdA} !== {1'b1, 1'b1, 4'h0, 13'h0, 32'h0}) begin
      errors++; $display("FAIL reset_mem got csn=%b wen=%b be=%h add=%h wd=%h", csnA, wenA, beA, addA, wdA);
    end
    checks++; if ({busyA, doneA} !== 2'b00) begin errors++; $display("FAIL reset_clear got %b exp 00", {busyA, doneA}); end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_arbitration();
    logic [1:0] expG, prevG;
    prevG = 2'b00;
    for (int c = 0; c < 7; c++) begin
      if (c < 6) begin
        drive(0, 1'b1, 1'b1, 13'h20, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b1, 13'h21, 4'hF, 32'h0);
      end else idle();
      #1;
      expG = (c >= 6) ? 2'b00 : ((c % 2 == 1) ? 2'b10 : 2'b01);
      checks++; if (gntA !== expG) begin errors++; $display("FAIL arb_gnt c=%0d got %b exp %b", c, gntA, expG); end
      checks++; if (rvA !== prevG) begin errors++; $display("FAIL arb_rvalid c=%0d got %b exp %b", c, rvA, prevG); end
      if (prevG != 2'b00) begin
        checks++;
        if (rdA !== pat(prevG[1] ? 32'h21 : 32'h20)) begin
          errors++; $display("FAIL arb_rdata c=%0d got %h exp %h", c, rdA, pat(prevG[1] ? 32'h21 : 32'h20));
        end
      end
      prevG = expG;
      tick();
    end
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 1'b0, 13'h10, 4'hF, 32'hDEADBEEF);
    #1;
    checks++; if (gntA !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b exp 01", gntA); end
    checks++; if ({csnA, wenA, addA, wdA, beA} !== {1'b0, 1'b0, 13'h10, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL wr_mem got csn=%b wen=%b add=%h wd=%h be=%h", csnA, wenA, addA, wdA, beA);
    end
    tick();
    drive(0, 1'b1, 1'b1, 13'h10, 4'hF, 32'h0);
    #1;
    checks++; if (rvA !== 2'b01) begin errors++; $display("FAIL wr_rvalid got %b exp 01", rvA); end
    checks++; if (rdA !== pat(32'h21)) begin errors++; $display("FAIL wr_rdata_hold got %h exp %h", rdA, pat(32'h21)); end
    checks++; if (gntA !== 2'b01) begin errors++; $display("FAIL rd_gnt got %b exp 01", gntA); end
    tick();
    idle();
    #1;
    checks++; if (rvA !== 2'b01) begin errors++; $display("FAIL rd_rvalid got %b exp 01", rvA); end
    checks++; if (rdA !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h exp deadbeef", rdA); end
    tick();
  endtask

  task automatic test_byte_enable();
    drive(1, 1'b1, 1'b0, 13'h5, 4'hF, 32'hFFFFFFFF);
    tick();
    drive(1, 1'b1, 1'b0, 13'h5, 4'b0101, 32'h11223344);
    #1;
    checks++; if (beA !== 4'b0101) begin errors++; $display("FAIL be_mem got %b exp 0101", beA); end
    checks++; if (gntA !== 2'b10) begin errors++; $display("FAIL be_gnt got %b exp 10", gntA); end
    tick();
    drive(1, 1'b1, 1'b1, 13'h5, 4'hF, 32'h0);
    tick();
    idle();
    #1;
    checks++; if (rvA !== 2'b10) begin errors++; $display("FAIL be_rvalid got %b exp 10", rvA); end
    checks++; if (rdA !== 32'hFF22FF44) begin errors++; $display("FAIL be_rdata got %h exp ff22ff44", rdA); end
    tick();
  endtask

  task automatic test_out_of_range();
    drive(0, 1'b1, 1'b1, 13'h1FFF, 4'hF, 32'h0);
    #1;
    checks++; if ({gntA, csnA} !== {2'b01, 1'b1}) begin errors++; $display("FAIL oor_rd gnt=%b csn=%b exp 01/1", gntA, csnA); end
    tick();
    drive(0, 1'b1, 1'b0, 13'd8100, 4'hF, 32'h12345678);
    #1;
    checks++; if ({rvA, rdA} !== {2'b01, 32'hBADACCE5}) begin errors++; $display("FAIL oor_rdata got %b/%h exp 01/badacce5", rvA, rdA); end
    checks++; if ({gntA, csnA} !== {2'b01, 1'b1}) begin errors++; $display("FAIL oor_wr gnt=%b csn=%b exp 01/1", gntA, csnA); end
    tick();
    idle();
    #1;
    checks++; if ({rvA, rdA} !== {2'b01, 32'hBADACCE5}) begin errors++; $display("FAIL oor_wr_rsp got %b/%h exp 01/badacce5", rvA, rdA); end
    checks++; if (memA[8100] !== pat(8100)) begin errors++; $display("FAIL oor_wr_dropped got %h exp %h", memA[8100], pat(8100)); end
    tick();
  endtask

  task automatic test_clear();
    drive(0, 1'b1, 1'b1, 13'h5, 4'hF, 32'h0);
    clrReqB = 1'b1;
    #1;
    checks++; if ({gntB, busyB} !== {2'b01, 1'b0}) begin errors++; $display("FAIL clr_first_gnt got %b/%b exp 01/0", gntB, busyB); end
    tick();
    clrReqB = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({busyB, gntB, csnB, wenB, beB, addB, wdB, doneB} !==
          {1'b1, 2'b00, 1'b0, 1'b0, 4'hF, 13'(i), 32'h0, (i == 15)}) begin
        errors++;
        $display("FAIL clr_cycle i=%0d got busy=%b gnt=%b csn=%b wen=%b be=%h add=%0d wd=%h done=%b",
                 i, busyB, gntB, csnB, wenB, beB, addB, wdB, doneB);
      end
      checks++; if (rvB !== ((i == 0) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL clr_rvalid i=%0d got %b", i, rvB); end
      tick();
    end
    checks++; if ({busyB, gntB, addB, csnB} !== {1'b0, 2'b01, 13'h5, 1'b0}) begin
      errors++; $display("FAIL clr_resume got busy=%b gnt=%b add=%h csn=%b", busyB, gntB, addB, csnB);
    end
    tick();
    idle();
    #1;
    checks++; if ({rvB, rdB} !== {2'b01, 32'h0}) begin errors++; $display("FAIL clr_readback got %b/%h exp 01/0", rvB, rdB); end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    bit found;
    found = 1'b0;
    clrReqB = 1'b1;
    tick();
    clrReqB = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (busyB && addB == 13'd6) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_wait got add=%0d busy=%b exp add 6", addB, busyB); end
    drive(1, 1'b1, 1'b1, 13'h9, 4'hF, 32'h0);
    tick();
    idle();
    #1;
    checks++; if ({busyB, addB, rvA} !== {1'b1, 13'd7, 2'b10}) begin
      errors++; $display("FAIL rst_mid_pre got busy=%b add=%0d rvA=%b", busyB, addB, rvA);
    end
    rstN = 1'b0;
    #1;
    checks++; if ({busyB, doneB, csnB, wenB, beB, addB, wdB, rvB, rdB} !==
                  {1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 13'h0, 32'h0, 2'b00, 32'h0}) begin
      errors++; $display("FAIL rst_mid_B got busy=%b csn=%b add=%0d rv=%b rd=%h", busyB, csnB, addB, rvB, rdB);
    end
    checks++; if ({rvA, rdA} !== {2'b00, 32'h0}) begin errors++; $display("FAIL rst_mid_A got %b/%h exp 00/0", rvA, rdA); end
    tick();
    rstN = 1'b1;
    tick();
    drive(0, 1'b1, 1'b1, 13'h3, 4'hF, 32'h0);
    #1;
    checks++; if ({gntB, busyB, csnB} !== {2'b01, 1'b0, 1'b0}) begin errors++; $display("FAIL rst_after_gnt got %b/%b/%b", gntB, busyB, csnB); end
    tick();
    idle();
    #1;
    checks++; if ({rvB, rdB} !== {2'b01, 32'h0}) begin errors++; $display("FAIL rst_after_rsp got %b/%h exp 01/0", rvB, rdB); end
    tick();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
